// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: the parity mode selector, the
// transmit FSM state encoding and the parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Payload is zero-extended to 8 bits by the caller, so unused bits do not
  // disturb the XOR.
  function automatic logic parity_of(input logic [7:0] data, input parity_t mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full and a pop while
// empty are silently ignored. DEPTH must be a power of two.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; level and pointers alone
  // decide which entries are valid, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples values from before the clock edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (!do_push && do_pop) level <= level - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: a FIFO feeds a start/data/parity/stop framer.
// The serial line is a registered copy of the state decode, one cycle behind.
module uart_tx
  import uart_pkg::*;
#(
  parameter int      CLK_PER_BIT = 1992,
  parameter int      DATA_BITS   = 8,
  parameter parity_t PARITY      = PAR_NONE,
  parameter int      STOP_BITS   = 1,
  parameter int      FIFO_DEPTH  = 16,
  localparam int     LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 out,
  output logic                 busy,
  output logic [LVL_W-1:0]     level
);

  // Wide enough for the longest interval, a two-bit stop period.
  localparam int               CNT_W     = $clog2(2 * CLK_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLK_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);

  tx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 line_active;
  logic                 line_next;
  logic [DATA_BITS-1:0] head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 load;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (valid),
    .push_data (in),
    .pop       (load),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign ready = !fifo_full;
  // line_active covers the last stop cycle, which trails the FSM by one clock.
  assign busy  = line_active || (state != TX_IDLE) || !fifo_empty;
  assign load  = !fifo_empty &&
                 ((state == TX_IDLE) || (state == TX_STOP && cnt == STOP_LAST));

  // NOTE: line_next gets a default before the case so no latch is inferred.
  always_comb begin
    line_next = 1'b1;
    case (state)
      TX_START:  line_next = 1'b0;
      TX_DATA:   line_next = shift[0];
      TX_PARITY: line_next = par_bit;
      default:   line_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= TX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      out         <= 1'b1;
      line_active <= 1'b0;
    end else begin
      out         <= line_next;
      line_active <= (state != TX_IDLE);
      case (state)
        TX_IDLE: begin
          if (load) begin
            state   <= TX_START;
            cnt     <= '0;
            shift   <= head;
            par_bit <= parity_of(8'(head), PARITY);
          end
        end
        TX_START: begin
          if (cnt == BIT_LAST) begin
            state   <= TX_DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= shift >> 1;
            if (bit_idx == DATA_LAST)
              state <= (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TX_PARITY: begin
          if (cnt == BIT_LAST) begin
            state <= TX_STOP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (cnt == STOP_LAST) begin
            cnt <= '0;
            // Chain straight into the next frame when data is waiting.
            if (load) begin
              state   <= TX_START;
              shift   <= head;
              par_bit <= parity_of(8'(head), PARITY);
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four framings side by side, each checked every cycle
// against a timeline model of the serial line, FIFO level and busy flag.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int NCFG  = 4;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NCYC  = 4096;

  localparam int      CFG_DB  [NCFG] = '{8, 8, 8, 7};
  localparam parity_t CFG_PAR [NCFG] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE};
  localparam int      CFG_SB  [NCFG] = '{1, 1, 1, 2};

  logic       CLK;
  logic       RST;
  logic       valid_v [NCFG];
  logic [7:0] din     [NCFG];
  logic       ready_v [NCFG];
  logic       out_v   [NCFG];
  logic       busy_v  [NCFG];
  logic [2:0] level_v [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int DB = CFG_DB[g];
    uart_tx #(
      .CLK_PER_BIT (CPB),
      .DATA_BITS   (DB),
      .PARITY      (CFG_PAR[g]),
      .STOP_BITS   (CFG_SB[g]),
      .FIFO_DEPTH  (DEPTH)
    ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .in    (din[g][DB-1:0]),
      .valid (valid_v[g]),
      .ready (ready_v[g]),
      .out   (out_v[g]),
      .busy  (busy_v[g]),
      .level (level_v[g])
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit armed  = 1'b0;

  // Model: expected line value and busy window per cycle, pops per edge.
  bit exp_out  [NCFG][NCYC];
  bit exp_busy [NCFG][NCYC];
  int pop_at   [NCFG][NCYC];
  int mlevel   [NCFG];
  int last_end [NCFG];
  bit acc      [NCFG];
  bit m_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lay a whole frame onto the timeline: start, LSB-first data, parity, stops.
  task automatic schedule(input int i, input logic [7:0] b, input int e);
    bit   frame_bits [16];
    int   nb;
    int   s;
    int   f;
    logic [7:0] data;
    data = b & 8'((1 << CFG_DB[i]) - 1);
    s = (e + 2 > last_end[i] + 1) ? e + 2 : last_end[i] + 1;
    nb = 0;
    frame_bits[nb] = 1'b0; nb++;
    for (int j = 0; j < CFG_DB[i]; j++) begin
      frame_bits[nb] = data[j]; nb++;
    end
    if (CFG_PAR[i] != PAR_NONE) begin
      frame_bits[nb] = (^data) ^ (CFG_PAR[i] == PAR_ODD); nb++;
    end
    for (int j = 0; j < CFG_SB[i]; j++) begin
      frame_bits[nb] = 1'b1; nb++;
    end
    f = nb * CPB;
    for (int t = 0; t < f; t++)
      if (s + t < NCYC) exp_out[i][s + t] = frame_bits[t / CPB];
    for (int t = s - 1; t < s + f; t++)
      if (t < NCYC) exp_busy[i][t] = 1'b1;
    pop_at[i][s - 1]++;
    last_end[i] = s + f - 1;
  endtask

  always @(posedge CLK) begin
    cyc = cyc + 1;
    for (int i = 0; i < NCFG; i++) begin
      acc[i] = 1'b0;
      if (RST) begin
        mlevel[i]   = 0;
        last_end[i] = cyc;
        for (int c = cyc; c < NCYC; c++) begin
          exp_out[i][c]  = 1'b1;
          exp_busy[i][c] = 1'b0;
          pop_at[i][c]   = 0;
        end
      end else begin
        m_ready   = (mlevel[i] < DEPTH);
        mlevel[i] = mlevel[i] - pop_at[i][cyc];
        if (valid_v[i] && m_ready) begin
          acc[i] = 1'b1;
          mlevel[i]++;
          schedule(i, din[i], cyc);
        end
      end
    end
    if (RST) armed = 1'b1;
  end

  always @(negedge CLK) begin
    if (cyc >= NCYC - 2) begin
      $display("FAIL watchdog: got cycle %0d expected below %0d", cyc, NCYC - 2);
      $fatal(1, "cycle budget exhausted");
    end
    if (armed) begin
      for (int i = 0; i < NCFG; i++) begin
        check($sformatf("out[%0d]", i),   32'(out_v[i]),   32'(exp_out[i][cyc]));
        check($sformatf("busy[%0d]", i),  32'(busy_v[i]),  32'(mlevel[i] > 0 || exp_busy[i][cyc]));
        check($sformatf("level[%0d]", i), 32'(level_v[i]), 32'(mlevel[i]));
        check($sformatf("ready[%0d]", i), 32'(ready_v[i]), 32'(mlevel[i] < DEPTH));
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic wait_idle();
    int m;
    m = 0;
    for (int i = 0; i < NCFG; i++) if (last_end[i] > m) m = last_end[i];
    wait_until(m + 3);
  endtask

  // Holds valid with byte b until the model reports acceptance; caller drops valid.
  task automatic push_seq(input int i, input logic [7:0] b, output int acc_edge);
    int n;
    n = 0;
    valid_v[i] = 1'b1;
    din[i]     = b;
    do begin
      @(negedge CLK);
      n++;
    end while (!acc[i] && n < 200);
    if (!acc[i]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout[%0d]: got no accept expected accept within 200 cycles", i);
    end
    acc_edge = cyc;
  endtask

  initial begin
    int k;
    int e;
    RST = 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      valid_v[i] = 1'b0;
      din[i]     = 8'h00;
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("rst_out",   32'(out_v[0]),   32'd1);
    check("rst_ready", 32'(ready_v[0]), 32'd1);
    check("rst_busy",  32'(busy_v[0]),  32'd0);
    check("rst_level", 32'(level_v[0]), 32'd0);
    repeat (2) @(negedge CLK);

    // One byte into every framing on the same edge.
    for (int i = 0; i < NCFG; i++) valid_v[i] = 1'b1;
    din[0] = 8'h55; din[1] = 8'h07; din[2] = 8'h07; din[3] = 8'h7F;
    @(negedge CLK);
    k = cyc;
    for (int i = 0; i < NCFG; i++) valid_v[i] = 1'b0;
    check("model_a_start", 32'(exp_out[0][k + 2]), 32'd0);
    check("model_b_len",   32'(last_end[1] - k - 1), 32'd44);
    check("model_d_len",   32'(last_end[3] - k - 1), 32'd40);
    wait_until(k + 1);  check("a_idle_before", 32'(out_v[0]), 32'd1);
    wait_until(k + 2);  check("a_start",       32'(out_v[0]), 32'd0);
    wait_until(k + 5);  check("a_start_end",   32'(out_v[0]), 32'd0);
    wait_until(k + 6);  check("a_bit0",        32'(out_v[0]), 32'd1);
    wait_until(k + 10); check("a_bit1",        32'(out_v[0]), 32'd0);
    wait_until(k + 33); check("d_bit6",        32'(out_v[3]), 32'd1);
    wait_until(k + 34); check("a_bit7",        32'(out_v[0]), 32'd0);
    check("d_stop", 32'(out_v[3]), 32'd1);
    wait_until(k + 38); check("a_stop",   32'(out_v[0]), 32'd1);
    check("b_even_par", 32'(out_v[1]), 32'd1);
    check("c_odd_par",  32'(out_v[2]), 32'd0);
    wait_until(k + 41); check("a_busy_last", 32'(busy_v[0]), 32'd1);
    wait_until(k + 42); check("a_busy_done", 32'(busy_v[0]), 32'd0);
    check("d_busy_done", 32'(busy_v[3]), 32'd0);
    wait_until(k + 45); check("b_busy_last", 32'(busy_v[1]), 32'd1);
    wait_until(k + 46); check("b_busy_done", 32'(busy_v[1]), 32'd0);

    // Back-to-back frames with no idle gap.
    wait_idle();
    push_seq(0, 8'hA0, k);
    push_seq(0, 8'h0F, e);
    valid_v[0] = 1'b0;
    check("b2b_accept", 32'(e - k), 32'd1);
    wait_until(k + 6);  check("a0_bit0",    32'(out_v[0]), 32'd0);
    wait_until(k + 26); check("a0_bit5",    32'(out_v[0]), 32'd1);
    wait_until(k + 41); check("a0_stop",    32'(out_v[0]), 32'd1);
    wait_until(k + 42); check("0f_start",   32'(out_v[0]), 32'd0);
    check("b2b_busy", 32'(busy_v[0]), 32'd1);
    wait_until(k + 46); check("0f_bit0",    32'(out_v[0]), 32'd1);

    // Hold valid across six bytes while the first frame runs.
    wait_idle();
    push_seq(0, 8'h10, k);
    for (int j = 1; j < 5; j++) push_seq(0, 8'(8'h10 + j), e);
    check("full_level", 32'(level_v[0]), 32'd4);
    check("full_ready", 32'(ready_v[0]), 32'd0);
    push_seq(0, 8'h15, e);
    valid_v[0] = 1'b0;
    check("sixth_accept", 32'(e - k), 32'd42);

    // Reset during data bit 3 with two bytes queued; a push in the reset cycle is dropped.
    wait_idle();
    push_seq(0, 8'hC3, k);
    push_seq(0, 8'h3C, e);
    push_seq(0, 8'h99, e);
    valid_v[0] = 1'b0;
    wait_until(k + 18);
    check("pre_rst_level", 32'(level_v[0]), 32'd2);
    RST        = 1'b1;
    valid_v[0] = 1'b1;
    din[0]     = 8'h33;
    @(negedge CLK);
    RST        = 1'b0;
    valid_v[0] = 1'b0;
    check("abort_out",   32'(out_v[0]),   32'd1);
    check("abort_level", 32'(level_v[0]), 32'd0);
    check("abort_busy",  32'(busy_v[0]),  32'd0);
    wait_until(k + 120);
    check("abort_quiet", 32'(out_v[0]), 32'd1);

    // Random traffic on all framings, with one reset in the middle.
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < NCFG; i++) begin
        if (!valid_v[i] || acc[i]) begin
          valid_v[i] = ($urandom_range(0, 2) == 0);
          din[i]     = 8'($urandom);
        end
      end
      RST = (t == 900);
      @(negedge CLK);
    end
    RST = 1'b0;
    for (int i = 0; i < NCFG; i++) valid_v[i] = 1'b0;
    wait_idle();
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("drain_busy[%0d]", i),  32'(busy_v[i]),  32'd0);
      check($sformatf("drain_level[%0d]", i), 32'(level_v[i]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_PER_BIT, default 1992, SHALL set clock cycles per serial bit period; legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, SHALL set payload bits per frame; legal range 5..8.
REQ-003 Parameter PARITY, default PAR_NONE, SHALL select the parity mode from PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-004 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 16, SHALL set transmit buffer entries; must be a power of two, at least 2.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 Port CLK SHALL be an input, 1 bit: the system clock; all state changes on its rising edge.
REQ-008 Port RST SHALL be an input, 1 bit: synchronous active-high reset.
REQ-009 Port in SHALL be an input, DATA_BITS wide: the byte to enqueue.
REQ-010 Port valid SHALL be an input, 1 bit: producer offers in.
REQ-011 Port ready SHALL be an output, 1 bit: buffer can accept; a transfer occurs on an edge where valid && ready.
REQ-012 Port out SHALL be an output, 1 bit: serial line, idle high.
REQ-013 Port busy SHALL be an output, 1 bit: high while a frame is on the line or the FIFO is non-empty.
REQ-014 Port level SHALL be an output, $clog2(FIFO_DEPTH)+1 bits wide: current FIFO occupancy.

Function
REQ-015 ready SHALL equal !(level == FIFO_DEPTH); it SHALL have no combinational dependence on valid.
REQ-016 A push while full SHALL be ignored, with no data change and no error state.
REQ-017 The transmit FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-018 Transition: IDLE -> START when the FIFO is non-empty; the head is popped into the shift register on that edge.
REQ-019 Transition: START -> DATA -> PARITY (only if PARITY != PAR_NONE) -> STOP.
REQ-020 Each START, DATA, PARITY and STOP bit SHALL last exactly CLK_PER_BIT cycles.
REQ-021 The bit counter SHALL run only outside IDLE and SHALL reload to 0 on every bit boundary.
REQ-022 out SHALL be 0 in START, 1 in STOP and IDLE, and shift[0] in DATA; data is sent LSB first, DATA_BITS bits.
REQ-023 The parity bit SHALL be the XOR of the data bits for PAR_EVEN, and its inverse for PAR_ODD.
REQ-024 STOP SHALL last STOP_BITS*CLK_PER_BIT cycles.
REQ-025 At the end of STOP, the FSM SHALL pop the next entry and enter START directly if the FIFO is non-empty, with zero idle cycles between frames; otherwise it SHALL go to IDLE.
REQ-026 Latency: with an empty FIFO in IDLE, out SHALL fall exactly 2 cycles after the accepting edge.
REQ-027 A simultaneous push and pop SHALL leave level unchanged and SHALL lose no data; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 Frame length SHALL be CLK_PER_BIT*(1+DATA_BITS+(PARITY!=PAR_NONE)+STOP_BITS) cycles.

Reset
REQ-029 On RST, the FIFO SHALL be cleared: level=0, pointers=0.
REQ-030 On RST, state SHALL become IDLE and the counters SHALL become 0.
REQ-031 On RST, out SHALL be 1, ready SHALL be 1, and busy SHALL be 0, on the cycle after the reset edge.
REQ-032 RST mid-frame SHALL abort the frame immediately, driving out=1 from the next cycle, and SHALL discard all queued bytes.
REQ-033 A push asserted in the same cycle as RST SHALL be discarded.

Structure
REQ-034 Package uart_pkg SHALL hold the parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD) and the tx_state_t enum.
REQ-035 The FIFO SHALL be sub-module sync_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/level.
REQ-036 The FSM, bit counter and shift register SHALL reside in uart_tx.

Verification (CLK_PER_BIT=4, FIFO_DEPTH=4 unless noted)
REQ-037 Scenario: defaults, push 0x55 in IDLE -> out=0 at cycle +2, then 1,0,1,0,1,0,1,0, then 1, each for 4 cycles; frame 40 cycles; busy low after.
REQ-038 Scenario: PARITY=PAR_EVEN, push 0x07 -> parity bit 1; PARITY=PAR_ODD, push 0x07 -> parity bit 0; frame 44 cycles.
REQ-039 Scenario: hold valid with 6 bytes while a frame runs -> level reaches 4 and ready=0; byte 6 is refused until the next pop; all accepted bytes appear on out in order.
REQ-040 Scenario: push 0xA0 and 0x0F on consecutive cycles -> the second start bit begins on the cycle after the first stop bit ends, with no idle gap.
REQ-041 Scenario: DATA_BITS=7, STOP_BITS=2, push 0x7F -> 7 data ones, then 8 stop-high cycles; total 40 cycles.
REQ-042 Scenario: assert RST during data bit 3 with 2 bytes queued -> out=1, level=0, busy=0 next cycle; no further frames are sent.
